// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-packed-BCD converter, one bit per clock.
// Optional leading-zero blank mask output enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank_mask
`endif
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]    bcd_work;
  logic [BW-1:0]    corr;
  logic [CW-1:0]    count;
  logic             ovf_sticky;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; the last shift is the one taken with count at 1
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SHIFT;
      S_SHIFT: if (count == CW'(1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Per-digit add-3 correction, 4-bit wrap with no carry between digits
  always_comb begin
    corr = bcd_work;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) corr[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] mask_c;
  logic              all_zero;

  // Leading-zero mask; the ones digit is never blanked
  always_comb begin
    mask_c   = '0;
    all_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero  = all_zero & (bcd_work[4*i +: 4] == 4'd0);
      mask_c[i] = all_zero;
    end
    mask_c[0] = 1'b0;
  end
`endif

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bin_sr     <= '0;
      bcd_work   <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_mask <= '0;
`endif
    end else begin
      done <= 1'b0;
      busy <= (state_nx != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start) begin
            bin_sr     <= bin_in;
            bcd_work   <= '0;
            count      <= CW'(WIDTH);
            ovf_sticky <= 1'b0;
          end
        end
        S_SHIFT: begin
          bcd_work <= {corr[BW-2:0], bin_sr[WIDTH-1]};
          bin_sr   <= {bin_sr[WIDTH-2:0], 1'b0};
          count    <= count - CW'(1);
          if (corr[BW-1]) ovf_sticky <= 1'b1;
        end
        S_DONE: begin
          bcd_out  <= bcd_work;
          overflow <= ovf_sticky;
          done     <= 1'b1;
`ifdef BIN2BCD_BLANK_EN
          blank_mask <= mask_c;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed table, handshake corner cases
// and randomized values against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] bin_in;
  logic        busy, done, overflow;
  logic [19:0] bcd_out;
`ifdef BIN2BCD_BLANK_EN
  logic [4:0]  blank_mask;
`endif

  int total = 0;
  int bad   = 0;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank_mask (blank_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  mask;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: decimal digits by repeated division
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_mask(input int unsigned v);
    logic [4:0] m;
    int unsigned p;
    m = '0;
    p = 10;
    for (int i = 1; i < 5; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  // Drive start now; returns #1 after the accepting edge
  task automatic launch(input logic [15:0] v, input bit hold);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts edges until done is seen; bounded
  task automatic wait_done(output int n, input bit scramble);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (scramble) bin_in = 16'd9;
    end
    if (!done) begin
      bad++;
      total++;
      $display("FAIL timeout waiting for done after %0d cycles", n);
    end
  endtask

  task automatic conv_check(input string nm, input logic [15:0] v,
                            input logic [19:0] exp_bcd, input logic [4:0] exp_mask);
    int n;
    @(negedge clk);
    launch(v, 1'b0);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    wait_done(n, 1'b0);
    chk({nm, "_lat"}, 32'(n), 32'd17);
    chk({nm, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    chk({nm, "_ovf"}, 32'(overflow), 32'd0);
    chk({nm, "_busy_in_done"}, 32'(busy), 32'd0);
`ifdef BIN2BCD_BLANK_EN
    chk({nm, "_mask"}, 32'(blank_mask), 32'(exp_mask));
`else
    if (exp_mask == 5'h1f) $display("note: unexpected mask");
`endif
    @(posedge clk); #1;
    chk({nm, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] r;

    vecs[0]  = '{16'd0,     20'h00000, 5'b11110};
    vecs[1]  = '{16'd65535, 20'h65535, 5'b00000};
    vecs[2]  = '{16'd1234,  20'h01234, 5'b10000};
    vecs[3]  = '{16'd9,     20'h00009, 5'b11110};
    vecs[4]  = '{16'd10,    20'h00010, 5'b11100};
    vecs[5]  = '{16'd99,    20'h00099, 5'b11100};
    vecs[6]  = '{16'd100,   20'h00100, 5'b11000};
    vecs[7]  = '{16'd999,   20'h00999, 5'b11000};
    vecs[8]  = '{16'd1000,  20'h01000, 5'b10000};
    vecs[9]  = '{16'd9999,  20'h09999, 5'b10000};
    vecs[10] = '{16'd10000, 20'h10000, 5'b00000};
    vecs[11] = '{16'd42,    20'h00042, 5'b11100};

    nrst = 1'b0; start = 1'b0; bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk); nrst = 1'b1;

    foreach (vecs[i]) conv_check($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].mask);

    // start held and bin_in changed while busy: a single done with the captured value
    @(negedge clk);
    launch(16'd1234, 1'b1);
    wait_done(n, 1'b1);
    start = 1'b0;
    chk("hold_lat", 32'(n), 32'd17);
    chk("hold_bcd", 32'(bcd_out), 32'h01234);
`ifdef BIN2BCD_BLANK_EN
    chk("hold_mask", 32'(blank_mask), 32'b10000);
`endif
    @(posedge clk); #1;
    chk("hold_done_width", 32'(done), 32'd0);
    chk("hold_no_restart", 32'(busy), 32'd0);

    // Back-to-back: new start in the done cycle
    @(negedge clk);
    launch(16'd42, 1'b0);
    wait_done(n, 1'b0);
    chk("b2b_first", 32'(bcd_out), 32'h00042);
    launch(16'd9999, 1'b0);
    chk("b2b_gap_busy", 32'(busy), 32'd1);
    chk("b2b_hold_prev", 32'(bcd_out), 32'h00042);
    wait_done(n, 1'b0);
    chk("b2b_lat", 32'(n), 32'd17);
    chk("b2b_second", 32'(bcd_out), 32'h09999);

    // Reset mid-conversion
    @(negedge clk);
    launch(16'd500, 1'b0);
    repeat (7) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_bcd", 32'(bcd_out), 32'd0);
    @(negedge clk); nrst = 1'b1;
    n = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("mid_rst_no_done", 32'(n), 32'd0);
    conv_check("after_rst", 16'd7, 20'h00007, 5'b11110);

    // Randomized values against the reference model
    for (int k = 0; k < 300; k++) begin
      r = 16'($urandom_range(0, 65535));
      conv_check($sformatf("rnd_%0d", r), r, ref_bcd(32'(r)), ref_mask(32'(r)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential double-dabble converter: binary value (e.g. from the keypad BCD-to-binary path or the ALU result) to packed BCD digits for the seven-segment display driver.
- Counterpart of the BCD-to-binary direction used on keypad entry.
- One bit per clock, with a start/busy/done handshake.
- Sits between the datapath result register and the display digit mux.

Parameters:
- WIDTH, 16, bit width of the binary input.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1; the default covers 65535.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  request conversion. Sampled only in IDLE.
- bin_in  input  WIDTH  binary operand. Captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd_out is updated.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0].
- overflow  output  1  set with done if any bit shifted out of the BCD register's top digit was nonzero. Cannot occur for legal parameters; it is a checker aid.

Behaviour:
- Reset:
  - Async on nrst low; all outputs and internal state clear while nrst is low.
  - busy=0, done=0, bcd_out=0, overflow=0, state=IDLE, shift count=0.
- State IDLE:
  - busy=0.
  - If start=1 at a rising edge: load bin shift register <= bin_in, BCD work register <= 0, count <= WIDTH, go to SHIFT.
- State SHIFT:
  - busy=1.
  - Each edge, in order: for each BCD digit, if digit >= 5 then add 3 (4-bit, no carry across digits). Then shift {bcd_work, bin_sr} left by 1. Then count <= count-1.
  - When the shift that brings count to 0 occurs, go to DONE.
- State DONE:
  - busy=1 for this one cycle.
  - At the next edge: bcd_out <= bcd_work, overflow <= sticky overflow flag, done <= 1, go to IDLE.
- done:
  - High for exactly one cycle, the cycle after the DONE-exit edge; cleared at the following edge.
  - busy=0 in that cycle.
- Latency:
  - Start accepted at edge E0; WIDTH shift edges E1..EWIDTH; bcd_out/done update at E(WIDTH+1).
  - Default WIDTH: done is visible 17 cycles after the start edge.
- Back-to-back: start may be asserted in the done cycle, since the state is IDLE. The new conversion begins without a gap, and bcd_out holds the previous result until its own done.
- start while busy=1: ignored; bin_in changes while busy are ignored.
- bcd_out: holds its last value indefinitely between conversions; only changes on a done edge.
- Reset mid-conversion: aborts immediately; no done pulse; bcd_out reads 0.
- Width rules: the add-3 correction uses 4-bit arithmetic per digit. The count register is ceil(log2(WIDTH+1)) bits.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- When defined:
  - Adds output blank_mask [DIGITS-1:0], registered with bcd_out on the done edge.
  - Bit i=1 when digit i and all higher digits are zero, i.e. a leading zero. Bit 0 is always 0, so value 0 displays as a single "0".
  - blank_mask resets to 0.
- When undefined: port absent; no extra logic.

Test Plan:
- Reset, then start with bin_in=0 -> done after 17 cycles, bcd_out=0x00000, overflow=0; with macro, blank_mask=5'b11110.
- bin_in=16'd65535 -> bcd_out=0x65535, overflow=0; with macro, blank_mask=5'b00000.
- bin_in=16'd1234, then start held high and bin_in changed to 16'd9 during busy -> single done, bcd_out=0x01234. Next conversion starts only when IDLE is sampled; blank_mask=5'b10000.
- Back-to-back: start=1 with 16'd42, then start=1 again in the done cycle with 16'd9999 -> bcd_out 0x00042, then 0x09999 exactly 17 cycles later; no idle gap.
- nrst pulsed low at cycle 8 of a conversion of 16'd500 -> busy, done, and bcd_out drop to 0 immediately. No done pulse follows; a subsequent start with 16'd7 yields 0x00007.
- Sweep bin_in 0..65535 against a reference model -> every bcd_out matches decimal value, overflow never set, done always exactly one cycle wide.
